mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single byte-serial external memory bus between two internal requesters: requester 0 is the CPU core, requester 1 is a debug/DMA port. Each granted transaction is atomic and runs as three handshaked byte beats on the bidirectional pins: address low, address high, then data. The block replaces the single-master bus sequencer, adds round-robin arbitration, a 2-flop handshake synchroniser and a per-beat timeout.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth on hs_in; minimum 2.
- TIMEOUT, 1023: maximum cycles a single beat may wait; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rN_req  in  1  request from requester N (N = 0,1); held high until rN_done
- rN_we  in  1  1 = write, 0 = read
- rN_addr  in  16  byte address
- rN_wdata  in  8  write data
- rN_done  out  1  one-cycle pulse: transaction finished
- rN_err  out  1  one-cycle pulse with rN_done: transaction aborted by timeout
- rdata  out  8  read data; valid from rN_done of a read, held until the next read completes
- hs_in  in  1  external handshake input, asynchronous
- hs_out  out  1  handshake output to external agent
- bus_in  in  8  pin input path
- bus_out  out  8  pin output path
- bus_oe  out  8  pin output enables, all-ones or all-zeros
- bus_rd, bus_wr  out  1  status: current transaction type, high while not IDLE
- owner  out  1  requester currently granted; valid while busy
- busy  out  1  high while not IDLE

## Operation
- FSM states: IDLE, ADDR_LO, ADDR_HI, DATA, FIN.
- IDLE: if any req is high, grant; on a tie, grant the requester not served last (last_owner, reset 1, so r0 wins first). Latch addr, we and wdata into internal registers; go to ADDR_LO. A requester changing its inputs after grant has no effect.
- Beat engine (per phase), with hs_s = synchronised hs_in:
  - ARM: wait for hs_s == 0.
  - DRIVE: hs_out = 1.
  - The beat completes in the cycle where hs_s == 1 and hs_out == 1. hs_out clears next edge, and the FSM advances to the next phase next edge.
- Drive per phase:
  - ADDR_LO: bus_out = addr[7:0], bus_oe = 8'hFF.
  - ADDR_HI: bus_out = addr[15:8], bus_oe = 8'hFF.
  - DATA, write: bus_out = wdata, bus_oe = 8'hFF.
  - DATA, read: bus_oe = 0; bus_in is captured into rdata at beat completion.
  - All other states: bus_oe = 0, bus_out = 0.
- FIN: pulse rN_done of owner for one cycle, update last_owner, return to IDLE. If req is still high in the next IDLE cycle, it is a new transaction.
- Timeout: the counter clears at each phase entry and increments every cycle in ARM/DRIVE. On reaching TIMEOUT: hs_out <= 0, go to FIN with rN_err = 1; rdata is not updated.
- Reset mid-transaction: all state clears asynchronously. The interrupted requester gets no done pulse and must re-request.

## Timing
- Reset values:
  - hs_out = 0, bus_oe = 0, bus_out = 0
  - rN_done = rN_err = 0
  - rdata = 0, busy = 0, owner = 0
  - bus_rd = bus_wr = 0
- Grant: req is sampled in IDLE, and ADDR_LO is entered on the next edge.
- hs_in to hs_s latency: SYNC_STAGES cycles.
- Minimum beat with the agent responding instantly: ARM 1 cycle, then DRIVE 1 + SYNC_STAGES cycles.
- Done: rN_done is high the cycle after the DATA beat completes. It is never asserted together with a grant of the same requester.
- Timeout fires exactly TIMEOUT cycles after phase entry if the beat has not completed.

## Structure
- Shared package: FSM state encoding, phase encoding (ADDR_LO / ADDR_HI / DATA), requester index constants.
- Sub-module hs_beat_engine: synchroniser, ARM/DRIVE sequencing, timeout counter. Inputs start/clear; outputs hs_out, beat_done, timeout.
- Top level: arbitration, latching, pin muxing, FIN/done generation.

## Test plan
- r0 write 0x1234 <- 0xA5, agent responds instantly -> bus shows 0x34, 0x12, 0xA5 on successive beats with oe=FF; r0_done pulses once; r1_done stays 0.
- r1 read 0xBEEF, agent returns 0x5C -> oe=0 during DATA; rdata=0x5C when r1_done pulses; rdata holds through a later write.
- r0 and r1 raise req in the same cycle, both held -> grants go r0, r1, r0, r1; no transaction interleaves beats of another.
- hs_in stuck high at request, then toggled low/high -> hs_out stays 0 until hs_s is seen low; the beat completes only after the low-high sequence.
- TIMEOUT=8, agent never raises hs_in -> hs_out drops; r0_done and r0_err pulse together 8 cycles after ADDR_LO entry; rdata unchanged.
- rst_n asserted during ADDR_HI -> hs_out, bus_oe and busy are 0 immediately (asynchronous); no done pulse; after release, a new r0 request completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared encodings for the external memory bus arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_DATA,
        ST_FIN
    } state_e;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_ADDR_LO,
        PH_ADDR_HI,
        PH_DATA
    } phase_e;

    typedef enum logic [1:0] {
        BE_IDLE,
        BE_ARM,
        BE_DRIVE
    } beat_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    function automatic phase_e phase_of(input state_e s);
        case (s)
            ST_ADDR_LO: return PH_ADDR_LO;
            ST_ADDR_HI: return PH_ADDR_HI;
            ST_DATA:    return PH_DATA;
            default:    return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_beat.sv
// rtl/mem_bus_arbiter_beat.sv - hs_beat_engine: handshake synchroniser, ARM/DRIVE sequencing, per-beat timeout
module hs_beat_engine
    import mem_bus_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    input  logic hs_in,
    output logic hs_out,
    output logic beat_done,
    output logic timeout
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    beat_state_e            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   hs_out_q, hs_out_d;
    logic                   hs_s;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], hs_in};
        hs_s      = sync_q[SYNC_STAGES-1];
        state_d   = state_q;
        hs_out_d  = hs_out_q;
        cnt_d     = cnt_q;
        beat_done = (state_q == BE_DRIVE) && hs_out_q && hs_s;
        // a beat that completes on the last allowed cycle is not a timeout
        timeout   = (TIMEOUT != 0) && (state_q != BE_IDLE) && (cnt_q == CNT_LAST) && !beat_done;

        if (state_q != BE_IDLE) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            BE_ARM: begin
                if (!hs_s) begin
                    state_d  = BE_DRIVE;
                    hs_out_d = 1'b1;
                end
            end
            BE_DRIVE: begin
                if (beat_done) begin
                    state_d  = BE_IDLE;
                    hs_out_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (timeout) begin
            state_d  = BE_IDLE;
            hs_out_d = 1'b0;
        end
        if (start) begin
            state_d  = BE_ARM;
            hs_out_d = 1'b0;
            cnt_d    = '0;
        end
        if (clear) begin
            state_d  = BE_IDLE;
            hs_out_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BE_IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            hs_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            hs_out_q <= hs_out_d;
        end
    end

    assign hs_out = hs_out_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter for the byte-serial external memory bus
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [15:0] r0_addr,
    input  logic [7:0]  r0_wdata,
    output logic        r0_done,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [15:0] r1_addr,
    input  logic [7:0]  r1_wdata,
    output logic        r1_done,
    output logic        r1_err,
    output logic [7:0]  rdata,
    input  logic        hs_in,
    output logic        hs_out,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        owner,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        eng_start, eng_clear;
    logic        beat_done, beat_timeout;
    phase_e      phase;

    hs_beat_engine #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) u_beat (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (eng_start),
        .clear    (eng_clear),
        .hs_in    (hs_in),
        .hs_out   (hs_out),
        .beat_done(beat_done),
        .timeout  (beat_timeout)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        eng_start    = 1'b0;
        eng_clear    = (state_q == ST_FIN);

        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    // on a tie, the requester not served last wins
                    owner_d   = (r0_req && r1_req) ? ~last_owner_q : r1_req;
                    we_d      = (owner_d == REQ_DBG) ? r1_we    : r0_we;
                    addr_d    = (owner_d == REQ_DBG) ? r1_addr  : r0_addr;
                    wdata_d   = (owner_d == REQ_DBG) ? r1_wdata : r0_wdata;
                    err_d     = 1'b0;
                    state_d   = ST_ADDR_LO;
                    eng_start = 1'b1;
                end
            end
            ST_ADDR_LO, ST_ADDR_HI, ST_DATA: begin
                if (beat_done) begin
                    if (state_q == ST_ADDR_LO) begin
                        state_d   = ST_ADDR_HI;
                        eng_start = 1'b1;
                    end else if (state_q == ST_ADDR_HI) begin
                        state_d   = ST_DATA;
                        eng_start = 1'b1;
                    end else begin
                        if (!we_q) begin
                            rdata_d = bus_in;
                        end
                        state_d = ST_FIN;
                    end
                end else if (beat_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        phase   = phase_of(state_q);
        bus_out = 8'h00;
        bus_oe  = 8'h00;
        case (phase)
            PH_ADDR_LO: begin
                bus_out = addr_q[7:0];
                bus_oe  = 8'hFF;
            end
            PH_ADDR_HI: begin
                bus_out = addr_q[15:8];
                bus_oe  = 8'hFF;
            end
            PH_DATA: begin
                if (we_q) begin
                    bus_out = wdata_q;
                    bus_oe  = 8'hFF;
                end
            end
            default: ;
        endcase

        busy    = (state_q != ST_IDLE);
        bus_rd  = busy && !we_q;
        bus_wr  = busy && we_q;
        owner   = owner_q;
        rdata   = rdata_q;
        r0_done = (state_q == ST_FIN) && (owner_q == REQ_CPU);
        r1_done = (state_q == ST_FIN) && (owner_q == REQ_DBG);
        r0_err  = r0_done && err_q;
        r1_err  = r1_done && err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_CPU;
            last_owner_q <= REQ_DBG;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_req, r0_we, r0_done, r0_err;
    logic [15:0] r0_addr;
    logic [7:0]  r0_wdata;
    logic        r1_req, r1_we, r1_done, r1_err;
    logic [15:0] r1_addr;
    logic [7:0]  r1_wdata;
    logic [7:0]  rdata, bus_in, bus_out, bus_oe;
    logic        hs_in, hs_out, bus_rd, bus_wr, owner, busy;

    logic        agent_auto;
    logic        hs_man;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] beat_out [0:31];
    logic [7:0] beat_oe  [0:31];
    logic       done_own [0:15];
    int         nb = 0;
    int         nd = 0;
    int         n0 = 0;
    int         n1 = 0;
    int         ne = 0;
    logic       prev_hs = 1'b0;

    mem_bus_arbiter #(
        .SYNC_STAGES(2),
        .TIMEOUT    (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .r0_req  (r0_req),
        .r0_we   (r0_we),
        .r0_addr (r0_addr),
        .r0_wdata(r0_wdata),
        .r0_done (r0_done),
        .r0_err  (r0_err),
        .r1_req  (r1_req),
        .r1_we   (r1_we),
        .r1_addr (r1_addr),
        .r1_wdata(r1_wdata),
        .r1_done (r1_done),
        .r1_err  (r1_err),
        .rdata   (rdata),
        .hs_in   (hs_in),
        .hs_out  (hs_out),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .bus_oe  (bus_oe),
        .bus_rd  (bus_rd),
        .bus_wr  (bus_wr),
        .owner   (owner),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instant agent echoes hs_out; manual mode lets a test script the handshake
    always_comb hs_in = agent_auto ? hs_out : hs_man;

    always @(negedge clk) begin
        if (hs_out && !prev_hs && nb < 32) begin
            beat_out[nb] = bus_out;
            beat_oe[nb]  = bus_oe;
            nb++;
        end
        prev_hs = hs_out;
        if (r0_done || r1_done) begin
            if (nd < 16) done_own[nd] = r1_done;
            nd++;
        end
        n0 += int'(r0_done);
        n1 += int'(r1_done);
        ne += int'(r0_err || r1_err);
    end

    task automatic clear_log();
        nb = 0; nd = 0; n0 = 0; n1 = 0; ne = 0;
    endtask

    task automatic wait_done(input int who, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            seen = (who == 1) ? r1_done : r0_done;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_wait_r%0d: got no done, required done within %0d cycles", who, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        agent_auto = 1'b1; hs_man = 1'b0; bus_in = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (hs_out !== 1'b0) begin n_fail++; $display("FAIL reset_hs_out: got %0b want 0", hs_out); end
        n_cmp++; if (bus_oe !== 8'h00) begin n_fail++; $display("FAIL reset_bus_oe: got %h want 00", bus_oe); end
        n_cmp++; if (bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus_out: got %h want 00", bus_out); end
        n_cmp++; if ({r0_done, r0_err, r1_done, r1_err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_done_err: got %b want 0000", {r0_done, r0_err, r1_done, r1_err}); end
        n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_cmp++; if ({busy, owner, bus_rd, bus_wr} !== 4'b0) begin
            n_fail++; $display("FAIL reset_status: got %b want 0000", {busy, owner, bus_rd, bus_wr}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_write();
        clear_log();
        agent_auto = 1'b1;
        r0_we = 1'b1; r0_addr = 16'h1234; r0_wdata = 8'hA5; r0_req = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy, bus_wr, bus_rd} !== 3'b110) begin
            n_fail++; $display("FAIL wr_status: got %b want 110", {busy, bus_wr, bus_rd}); end
        wait_done(0, 80);
        r0_req = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (nb !== 3) begin n_fail++; $display("FAIL wr_beats: got %0d want 3", nb); end
        n_cmp++; if ({beat_out[0], beat_out[1], beat_out[2]} !== 24'h3412A5) begin
            n_fail++; $display("FAIL wr_bus: got %h%h%h want 3412a5", beat_out[0], beat_out[1], beat_out[2]); end
        n_cmp++; if ({beat_oe[0], beat_oe[1], beat_oe[2]} !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL wr_oe: got %h%h%h want ffffff", beat_oe[0], beat_oe[1], beat_oe[2]); end
        n_cmp++; if (n0 !== 1 || n1 !== 0 || ne !== 0) begin
            n_fail++; $display("FAIL wr_done: got r0=%0d r1=%0d err=%0d want 1 0 0", n0, n1, ne); end
    endtask

    task automatic test_read();
        clear_log();
        bus_in = 8'h5C;
        r1_we = 1'b0; r1_addr = 16'hBEEF; r1_wdata = 8'h00; r1_req = 1'b1;
        wait_done(1, 80);
        n_cmp++; if (rdata !== 8'h5C) begin n_fail++; $display("FAIL rd_rdata: got %h want 5c", rdata); end
        r1_req = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if ({beat_out[0], beat_out[1]} !== 16'hEFBE) begin
            n_fail++; $display("FAIL rd_addr: got %h%h want efbe", beat_out[0], beat_out[1]); end
        n_cmp++; if ({beat_oe[0], beat_oe[1], beat_oe[2]} !== 24'hFFFF00) begin
            n_fail++; $display("FAIL rd_oe: got %h%h%h want ffff00", beat_oe[0], beat_oe[1], beat_oe[2]); end
        n_cmp++; if (n1 !== 1 || n0 !== 0) begin
            n_fail++; $display("FAIL rd_done: got r0=%0d r1=%0d want 0 1", n0, n1); end

        bus_in = 8'h99;
        r0_we = 1'b1; r0_addr = 16'h0001; r0_wdata = 8'h77; r0_req = 1'b1;
        wait_done(0, 80);
        r0_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (rdata !== 8'h5C) begin n_fail++; $display("FAIL rd_hold: got %h want 5c", rdata); end
    endtask

    task automatic test_stuck_high();
        bit bad = 1'b0;
        bit fell = 1'b0;
        clear_log();
        agent_auto = 1'b0; hs_man = 1'b1;
        repeat (4) @(negedge clk);
        r0_we = 1'b1; r0_addr = 16'h00AB; r0_wdata = 8'h3C; r0_req = 1'b1;
        @(negedge clk);
        if (hs_out !== 1'b0) bad = 1'b1;
        hs_man = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (hs_out !== 1'b0) bad = 1'b1;
        end
        n_cmp++; if (bad) begin n_fail++; $display("FAIL stuck_arm: got hs_out=1 while hs_s high, want 0"); end
        @(negedge clk);
        n_cmp++; if (hs_out !== 1'b1) begin n_fail++; $display("FAIL stuck_drive: got %0b want 1", hs_out); end
        @(negedge clk);
        n_cmp++; if (hs_out !== 1'b1) begin n_fail++; $display("FAIL stuck_hold_low: got %0b want 1", hs_out); end
        hs_man = 1'b1;
        for (int k = 0; k < 4 && !fell; k++) begin
            @(negedge clk);
            fell = !hs_out;
        end
        n_cmp++; if (!fell) begin n_fail++; $display("FAIL stuck_complete: got hs_out=1 want 0 within 4 cycles"); end
        agent_auto = 1'b1;
        wait_done(0, 80);
        r0_req = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if ({beat_out[0], beat_out[1], beat_out[2]} !== 24'hAB003C || nb !== 3 || ne !== 0) begin
            n_fail++; $display("FAIL stuck_bus: got %h%h%h n=%0d err=%0d want ab003c 3 0",
                               beat_out[0], beat_out[1], beat_out[2], nb, ne); end
    endtask

    task automatic test_timeout();
        bit early = 1'b0;
        clear_log();
        agent_auto = 1'b0; hs_man = 1'b0; bus_in = 8'hEE;
        repeat (3) @(negedge clk);
        r0_we = 1'b0; r0_addr = 16'h0BAD; r0_req = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_entry: got busy=%0b want 1", busy); end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (r0_done || r0_err) early = 1'b1;
        end
        n_cmp++; if (early) begin n_fail++; $display("FAIL to_early: got done before cycle 8, want none"); end
        n_cmp++; if (hs_out !== 1'b1) begin n_fail++; $display("FAIL to_drive: got %0b want 1", hs_out); end
        @(negedge clk);
        n_cmp++; if ({r0_done, r0_err, hs_out} !== 3'b110) begin
            n_fail++; $display("FAIL to_fire: got done/err/hs=%b want 110", {r0_done, r0_err, hs_out}); end
        n_cmp++; if (rdata !== 8'h5C) begin n_fail++; $display("FAIL to_rdata: got %h want 5c", rdata); end
        r0_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int got = 0;
        logic [7:0] exp_b;
        do_reset();
        clear_log();
        agent_auto = 1'b1;
        r0_we = 1'b1; r0_addr = 16'h1111; r0_wdata = 8'h11;
        r1_we = 1'b1; r1_addr = 16'h2222; r1_wdata = 8'h22;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int k = 0; k < 300 && got < 4; k++) begin
            @(negedge clk);
            if (r0_done || r1_done) got++;
        end
        r0_req = 1'b0; r1_req = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (nd !== 4) begin n_fail++; $display("FAIL rr_count: got %0d want 4", nd); end
        n_cmp++; if ({done_own[0], done_own[1], done_own[2], done_own[3]} !== 4'b0101) begin
            n_fail++; $display("FAIL rr_order: got %b want 0101",
                               {done_own[0], done_own[1], done_own[2], done_own[3]}); end
        for (int b = 0; b < 12; b++) begin
            exp_b = ((b / 3) % 2 == 0) ? 8'h11 : 8'h22;
            n_cmp++;
            if (beat_out[b] !== exp_b || beat_oe[b] !== 8'hFF) begin
                n_fail++; $display("FAIL rr_beat%0d: got %h/%h want %h/ff", b, beat_out[b], beat_oe[b], exp_b);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        clear_log();
        agent_auto = 1'b1;
        r0_we = 1'b1; r0_addr = 16'h4321; r0_wdata = 8'h5A; r0_req = 1'b1;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            found = hs_out && (bus_out == 8'h43) && (bus_oe == 8'hFF);
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL rm_reach: got no ADDR_HI drive, want one"); end
        #2;
        rst_n = 1'b0; r0_req = 1'b0;
        #1;
        n_cmp++; if ({hs_out, bus_oe, busy} !== 10'b0) begin
            n_fail++; $display("FAIL rm_async: got hs=%0b oe=%h busy=%0b want 0 00 0", hs_out, bus_oe, busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (n0 !== 0) begin n_fail++; $display("FAIL rm_nodone: got %0d done want 0", n0); end
        clear_log();
        r0_we = 1'b1; r0_addr = 16'h0F0F; r0_wdata = 8'hF0; r0_req = 1'b1;
        wait_done(0, 80);
        r0_req = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if ({beat_out[0], beat_out[1], beat_out[2]} !== 24'h0F0FF0 || n0 !== 1) begin
            n_fail++; $display("FAIL rm_after: got %h%h%h done=%0d want 0f0ff0 1",
                               beat_out[0], beat_out[1], beat_out[2], n0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stuck_high();
        test_timeout();
        test_round_robin();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
